// File: rtl/afisaj_pkg.sv
// Shared glyph codes and display-mode encoding for the multiplexed 7-segment driver.
package afisaj_pkg;

  localparam logic [3:0] GLYPH_0       = 4'd0;
  localparam logic [3:0] GLYPH_1       = 4'd1;
  localparam logic [3:0] GLYPH_2       = 4'd2;
  localparam logic [3:0] GLYPH_3       = 4'd3;
  localparam logic [3:0] GLYPH_4       = 4'd4;
  localparam logic [3:0] GLYPH_5       = 4'd5;
  localparam logic [3:0] GLYPH_6       = 4'd6;
  localparam logic [3:0] GLYPH_7       = 4'd7;
  localparam logic [3:0] GLYPH_8       = 4'd8;
  localparam logic [3:0] GLYPH_9       = 4'd9;
  localparam logic [3:0] GLYPH_ARROW_R = 4'd10;
  localparam logic [3:0] GLYPH_ARROW_L = 4'd11;
  localparam logic [3:0] GLYPH_DASH    = 4'd12;
  localparam logic [3:0] GLYPH_BLANK   = 4'd13;
  localparam logic [3:0] GLYPH_FULL    = 4'd14;

  typedef enum logic [1:0] {
    ModeStop   = 2'd0,
    ModeNumber = 2'd1,
    ModeLeft   = 2'd2,
    ModeRight  = 2'd3
  } mode_e;

endpackage

// File: rtl/afisaj_multiplexat_param_decodor_7seg.sv
// Glyph code to active-high {a,b,c,d,e,f,g} segment pattern.
module decodor_7seg
  import afisaj_pkg::*;
(
  input  logic [3:0] glyph_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'b0000000;
    case (glyph_i)
      GLYPH_0:       seg_o = 7'b1111110;
      GLYPH_1:       seg_o = 7'b0110000;
      GLYPH_2:       seg_o = 7'b1101101;
      GLYPH_3:       seg_o = 7'b1111001;
      GLYPH_4:       seg_o = 7'b0110011;
      GLYPH_5:       seg_o = 7'b1011011;
      GLYPH_6:       seg_o = 7'b1011111;
      GLYPH_7:       seg_o = 7'b1110000;
      GLYPH_8:       seg_o = 7'b1111111;
      GLYPH_9:       seg_o = 7'b1111011;
      GLYPH_ARROW_R: seg_o = 7'b1111001;
      GLYPH_ARROW_L: seg_o = 7'b1001111;
      GLYPH_DASH:    seg_o = 7'b0000001;
      GLYPH_FULL:    seg_o = 7'b1111111;
      default:       seg_o = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/afisaj_multiplexat_param.sv
// Multiplexed 7-segment driver: per-frame glyph buffering, anti-ghost blanking,
// blinking turn arrows and selectable output polarity.
module afisaj_multiplexat_param
  import afisaj_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned PRESCALE       = 50000,
  parameter int unsigned BLANK_CYCLES   = 500,
  parameter int unsigned BLINK_FRAMES   = 64,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stop,
  input  logic                    semnal_stanga,
  input  logic                    semnal_dreapta,
  input  logic [4*NUM_DIGITS-1:0] value_bcd,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int unsigned CntW   = $clog2(PRESCALE);
  localparam int unsigned SlotW  = $clog2(NUM_DIGITS);
  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  if (BLANK_CYCLES >= PRESCALE) begin : g_chk_blank
    $fatal(1, "BLANK_CYCLES must be smaller than PRESCALE");
  end
  if (NUM_DIGITS < 2) begin : g_chk_digits
    $fatal(1, "NUM_DIGITS must be at least 2");
  end
  if (PRESCALE < 2) begin : g_chk_prescale
    $fatal(1, "PRESCALE must be at least 2");
  end

  logic [CntW-1:0]              cnt_q, cnt_d;
  logic [SlotW-1:0]             slot_q, slot_d;
  logic [NUM_DIGITS-1:0][3:0]   glyph_q, glyph_d, glyph_load;
  logic [BlinkW-1:0]            blink_cnt_q, blink_cnt_d, blink_cnt_nxt, eff_cnt;
  logic                         blink_phase_q, blink_phase_d, blink_phase_nxt, eff_phase;
  mode_e                        mode_q, mode_d, mode_now;
  logic [NUM_DIGITS-1:0]        dig_en_q, dig_en_d, dig_onehot;
  logic [6:0]                   seg_q, seg_d, seg_raw;
  logic                         frame_tick_q, frame_end;
  logic [SlotW-1:0]             slot_rev;
  logic [3:0]                   cur_glyph, nib;
  logic                         lz_run, entering;

  // Glyphs and blink state that the next frame boundary would commit.
  always_comb begin
    mode_now = stop ? ModeStop :
               (semnal_stanga == semnal_dreapta) ? ModeNumber :
               semnal_stanga ? ModeLeft : ModeRight;
    entering  = (mode_now != mode_q);
    eff_phase = entering ? 1'b1 : blink_phase_q;
    eff_cnt   = entering ? '0 : blink_cnt_q;

    if (mode_now == ModeStop || mode_now == ModeNumber) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b1;
    end else if (eff_cnt == BlinkW'(BLINK_FRAMES - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~eff_phase;
    end else begin
      blink_cnt_nxt   = eff_cnt + 1'b1;
      blink_phase_nxt = eff_phase;
    end

    glyph_load = {NUM_DIGITS{GLYPH_BLANK}};
    lz_run     = blank_lz;
    nib        = 4'd0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib    = value_bcd[4*i +: 4];
      // Rightmost digit always shows, so a zero value still reads '0'.
      lz_run = lz_run && (nib == 4'd0) && (i != 0);
      unique case (mode_now)
        ModeStop:   glyph_load[i] = GLYPH_FULL;
        ModeNumber: glyph_load[i] = lz_run ? GLYPH_BLANK :
                                    (nib > 4'd9) ? GLYPH_DASH : nib;
        ModeLeft:   glyph_load[i] = (i == int'(NUM_DIGITS) - 1) ?
                                    (eff_phase ? GLYPH_ARROW_L : GLYPH_BLANK) : GLYPH_DASH;
        ModeRight:  glyph_load[i] = (i == 0) ?
                                    (eff_phase ? GLYPH_ARROW_R : GLYPH_BLANK) : GLYPH_DASH;
        default:    glyph_load[i] = GLYPH_BLANK;
      endcase
    end
  end

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    slot_d        = slot_q;
    glyph_d       = glyph_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    mode_d        = mode_q;
    frame_end     = 1'b0;
    if (cnt_q == CntW'(PRESCALE - 1)) begin
      cnt_d = '0;
      if (slot_q == SlotW'(NUM_DIGITS - 1)) begin
        slot_d    = '0;
        frame_end = 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
    if (frame_end) begin
      glyph_d       = glyph_load;
      blink_cnt_d   = blink_cnt_nxt;
      blink_phase_d = blink_phase_nxt;
      mode_d        = mode_now;
    end
  end

  // Slot 0 is the leftmost digit, which lives in the top nibble / top enable bit.
  assign slot_rev  = SlotW'(NUM_DIGITS - 1) - slot_q;
  assign cur_glyph = glyph_q[slot_rev];

  decodor_7seg u_decodor_7seg (
    .glyph_i (cur_glyph),
    .seg_o   (seg_raw)
  );

  always_comb begin
    dig_onehot = '0;
    if (cnt_q >= CntW'(BLANK_CYCLES)) begin
      dig_onehot[slot_rev] = 1'b1;
    end
    dig_en_d = dig_onehot ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
    seg_d    = seg_raw ^ {7{SEG_ACTIVE_LOW}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      glyph_q       <= {NUM_DIGITS{GLYPH_BLANK}};
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      mode_q        <= ModeNumber;
      dig_en_q      <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
      seg_q         <= {7{SEG_ACTIVE_LOW}};
      frame_tick_q  <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      glyph_q       <= glyph_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      mode_q        <= mode_d;
      dig_en_q      <= dig_en_d;
      seg_q         <= seg_d;
      frame_tick_q  <= frame_end;
    end
  end

  assign dig_en     = dig_en_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_afisaj_multiplexat_param.sv
// Scoreboard bench: each frame's expected segment patterns are queued when the inputs
// are driven and compared slot by slot once the DUT starts displaying that frame.
module tb_afisaj_multiplexat_param;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned Prescale  = 8;
  localparam int unsigned Blank     = 2;
  localparam int unsigned Frame     = NumDigits * Prescale;

  // Active-low segment patterns {a..g}.
  localparam logic [6:0] SFull = 7'b0000000;
  localparam logic [6:0] SBl   = 7'b1111111;
  localparam logic [6:0] SDash = 7'b1111110;
  localparam logic [6:0] SAl   = 7'b0110000;
  localparam logic [6:0] SAr   = 7'b0000110;
  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] S8    = 7'b0000000;
  localparam logic [6:0] S9    = 7'b0000100;

  logic        clock = 1'b0;
  logic        reset;
  logic        stop, semnal_stanga, semnal_dreapta, blank_lz;
  logic [15:0] value_bcd;
  logic [3:0]  dig_en;
  logic [6:0]  seg;
  logic        frame_tick;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_tick;
  bit          have_last = 1'b0;

  logic [27:0] exp_q[$];

  afisaj_multiplexat_param #(
    .NUM_DIGITS     (NumDigits),
    .PRESCALE       (Prescale),
    .BLANK_CYCLES   (Blank),
    .BLINK_FRAMES   (2),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b0)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stop           (stop),
    .semnal_stanga  (semnal_stanga),
    .semnal_dreapta (semnal_dreapta),
    .value_bcd      (value_bcd),
    .blank_lz       (blank_lz),
    .dig_en         (dig_en),
    .seg            (seg),
    .frame_tick     (frame_tick)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // frame_tick must be a single-cycle pulse every Frame cycles outside reset.
  always @(negedge clock) begin
    if (reset) begin
      have_last = 1'b0;
    end else if (frame_tick) begin
      if (have_last) check_eq("tick_period", cyc - last_tick, Frame);
      last_tick = cyc;
      have_last = 1'b1;
    end
  end

  // Drive one frame's inputs, queue its expected slots, then check the displayed frame.
  task automatic run_frame(input logic st, input logic l, input logic r, input logic [15:0] val,
                           input logic lz, input logic [27:0] exp, input logic mid_en,
                           input logic [15:0] mid_val);
    logic [27:0] cur;
    bit          seen;
    int unsigned slot, cnt;
    stop           = st;
    semnal_stanga  = l;
    semnal_dreapta = r;
    value_bcd      = val;
    blank_lz       = lz;
    exp_q.push_back(exp);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    cur = exp_q.pop_front();
    if (!seen) begin
      check_eq("tick_timeout", 32'd0, 32'd1);
      return;
    end
    for (int c = 0; c < int'(Frame) - 1; c++) begin
      @(negedge clock);
      slot = c / Prescale;
      cnt  = c % Prescale;
      check_eq("seg", seg, cur[27 - 7*slot -: 7]);
      check_eq("dig_en", dig_en, (cnt >= Blank) ? (4'b1000 >> slot) : 4'b0000);
      if (mid_en && c == 12) value_bcd = mid_val;
    end
  endtask

  initial begin
    int unsigned k;
    bit          seen;
    reset          = 1'b1;
    stop           = 1'b0;
    semnal_stanga  = 1'b0;
    semnal_dreapta = 1'b0;
    value_bcd      = 16'h0000;
    blank_lz       = 1'b0;
    #12;
    check_eq("rst_dig_en", dig_en, 4'b0000);
    check_eq("rst_seg", seg, SBl);
    check_eq("rst_tick", frame_tick, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Number mode and leading-zero blanking.
    run_frame(0, 0, 0, 16'h0042, 1, {SBl, SBl, S4, S2}, 0, 16'h0);
    run_frame(0, 0, 0, 16'h0000, 1, {SBl, SBl, SBl, S0}, 0, 16'h0);
    run_frame(0, 0, 0, 16'h0042, 0, {S0, S0, S4, S2}, 0, 16'h0);
    run_frame(0, 0, 0, 16'h0C42, 1, {SBl, SDash, S4, S2}, 0, 16'h0);
    run_frame(0, 0, 0, 16'h9081, 1, {S9, S0, S8, S1}, 0, 16'h0);

    // Tear-free: mid-frame change stays invisible until the next boundary.
    run_frame(0, 0, 0, 16'h0042, 1, {SBl, SBl, S4, S2}, 1, 16'h0077);
    run_frame(0, 0, 0, 16'h0077, 1, {SBl, SBl, S7, S7}, 0, 16'h0);

    // Left arrow blinks two frames on, two off.
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SBl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SBl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);

    // Both signals: number mode.
    run_frame(0, 1, 1, 16'h0042, 1, {SBl, SBl, S4, S2}, 0, 16'h0);

    // Right arrow starts in the shown phase.
    run_frame(0, 0, 1, 16'h0042, 1, {SDash, SDash, SDash, SAr}, 0, 16'h0);
    run_frame(0, 0, 1, 16'h0042, 1, {SDash, SDash, SDash, SAr}, 0, 16'h0);
    run_frame(0, 0, 1, 16'h0042, 1, {SDash, SDash, SDash, SBl}, 0, 16'h0);

    // Stop overrides the turn signal and holds steady.
    for (int f = 0; f < 5; f++) begin
      run_frame(1, 1, 0, 16'h0042, 1, {SFull, SFull, SFull, SFull}, 0, 16'h0);
    end
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SAl, SDash, SDash, SDash}, 0, 16'h0);
    run_frame(0, 1, 0, 16'h0042, 1, {SBl, SDash, SDash, SDash}, 0, 16'h0);

    // Asynchronous reset at slot 2, cnt 5.
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("tick_timeout_rst", 32'd0, 32'd1);
    repeat (21) @(posedge clock);
    #2;
    check_eq("pre_rst_dig_en", dig_en, 4'b0010);
    reset = 1'b1;
    #1;
    check_eq("async_rst_dig_en", dig_en, 4'b0000);
    check_eq("async_rst_seg", seg, SBl);
    check_eq("async_rst_tick", frame_tick, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("held_rst_seg", seg, SBl);
    reset = 1'b0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == 1) check_eq("restart_slot0_blank", dig_en, 4'b0000);
      if (i == 3) check_eq("restart_slot0_active", dig_en, 4'b1000);
      if (frame_tick) begin
        k = i;
        break;
      end
    end
    check_eq("first_tick_after_rst", k, Frame);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
